// File: rtl/ysyx_25040129_trap_seq_pkg.sv
// Shared definitions for the trap/mret CSR sequencer: CSR addresses,
// state encodings, mstatus bit positions and an alignment helper.
package ysyx_25040129_trap_seq_pkg;

  // CSR address width and machine CSR addresses
  localparam int          CSR_DIG     = 12;
  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  // Sequencer state encodings
  localparam logic [2:0] TSEQ_IDLE    = 3'd0;
  localparam logic [2:0] TSEQ_T_EPC   = 3'd1;
  localparam logic [2:0] TSEQ_T_CAUSE = 3'd2;
  localparam logic [2:0] TSEQ_T_STAT  = 3'd3;
  localparam logic [2:0] TSEQ_T_JUMP  = 3'd4;
  localparam logic [2:0] TSEQ_R_STAT  = 3'd5;
  localparam logic [2:0] TSEQ_R_JUMP  = 3'd6;

  // mstatus bit positions
  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;

  typedef enum logic [2:0] {
    S_IDLE    = TSEQ_IDLE,
    S_T_EPC   = TSEQ_T_EPC,
    S_T_CAUSE = TSEQ_T_CAUSE,
    S_T_STAT  = TSEQ_T_STAT,
    S_T_JUMP  = TSEQ_T_JUMP,
    S_R_STAT  = TSEQ_R_STAT,
    S_R_JUMP  = TSEQ_R_JUMP
  } tseq_state_e;

  // Force a PC/vector to a 4-byte boundary (mtvec is used in direct mode only)
  function automatic logic [31:0] align4(input logic [31:0] v);
    return {v[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/ysyx_25040129_trap_seq_mstatus_upd.sv
// Combinational mstatus update for trap entry (is_mret=0) and mret (is_mret=1).
// MPP is always forced to machine mode since only M-mode is implemented.
module ysyx_25040129_mstatus_upd
  import ysyx_25040129_trap_seq_pkg::*;
(
  input  logic [31:0] mstatus_old,
  input  logic        is_mret,
  output logic [31:0] mstatus_new
);

  // Stack/unstack the interrupt-enable bits and force MPP to M-mode
  always_comb begin
    mstatus_new = mstatus_old;
    if (is_mret) begin
      mstatus_new[MSTATUS_MIE]  = mstatus_old[MSTATUS_MPIE];
      mstatus_new[MSTATUS_MPIE] = 1'b1;
    end else begin
      mstatus_new[MSTATUS_MPIE] = mstatus_old[MSTATUS_MIE];
      mstatus_new[MSTATUS_MIE]  = 1'b0;
    end
    mstatus_new[MSTATUS_MPP_LO +: 2] = 2'b11;
  end

endmodule

// File: rtl/ysyx_25040129_trap_seq.sv
// Trap-entry / mret sequencer for a single-write-port machine CSR file.
// Breaks each event into one CSR write per cycle followed by a one-cycle
// PC redirect, and shares the CSR ports with the EXU while idle.
// Optional build macro TRAP_MSTATUS_EN: when defined, the mstatus update
// states (T_STAT, R_STAT) are included; when undefined mstatus is untouched.
module ysyx_25040129_trap_seq
  import ysyx_25040129_trap_seq_pkg::*;
#(
  parameter int CSR_AW = CSR_DIG
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              trap_valid,
  input  logic [31:0]       trap_cause,
  input  logic [31:0]       trap_pc,
  input  logic              mret_valid,
  output logic              req_ready,
  input  logic              exu_csr_we,
  input  logic [CSR_AW-1:0] exu_csr_waddr,
  input  logic [31:0]       exu_csr_wdata,
  input  logic [CSR_AW-1:0] exu_csr_raddr,
  output logic [31:0]       exu_csr_rdata,
  output logic              exu_stall,
  output logic              csr_write,
  output logic [CSR_AW-1:0] csr_write_addr,
  output logic [31:0]       csr_data,
  output logic [CSR_AW-1:0] csr_read_addr,
  input  logic [31:0]       csr_out,
  output logic              redirect_valid,
  output logic [31:0]       redirect_pc
);

  tseq_state_e state_q, state_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] pc_q, pc_d;

`ifdef TRAP_MSTATUS_EN
  logic        is_mret_s;
  logic [31:0] mstatus_new_s;

  assign is_mret_s = (state_q == S_R_STAT);

  ysyx_25040129_mstatus_upd u_mstatus_upd (
    .mstatus_old (csr_out),
    .is_mret     (is_mret_s),
    .mstatus_new (mstatus_new_s)
  );
`endif

  // State and request-latch registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cause_q <= 32'h0;
      pc_q    <= 32'h0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      pc_q    <= pc_d;
    end
  end

  // Next-state logic and CSR port arbitration
  always_comb begin
    state_d        = state_q;
    cause_d        = cause_q;
    pc_d           = pc_q;
    req_ready      = 1'b0;
    exu_stall      = 1'b1;
    exu_csr_rdata  = 32'h0;
    csr_write      = 1'b0;
    csr_write_addr = '0;
    csr_data       = 32'h0;
    csr_read_addr  = '0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    case (state_q)
      S_IDLE: begin
        // EXU owns the CSR ports; an EXU write in the accept cycle still
        // lands because the first sequencer write is one cycle later.
        req_ready      = 1'b1;
        exu_stall      = 1'b0;
        csr_write      = exu_csr_we;
        csr_write_addr = exu_csr_waddr;
        csr_data       = exu_csr_wdata;
        csr_read_addr  = exu_csr_raddr;
        exu_csr_rdata  = csr_out;
        if (trap_valid) begin
          state_d = S_T_EPC;
          cause_d = trap_cause;
          pc_d    = trap_pc;
        end else if (mret_valid) begin
`ifdef TRAP_MSTATUS_EN
          state_d = S_R_STAT;
`else
          state_d = S_R_JUMP;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_T_EPC: begin
        csr_write      = 1'b1;
        csr_write_addr = CSR_AW'(CSR_MEPC);
        csr_data       = align4(pc_q);
        state_d        = S_T_CAUSE;
      end
      S_T_CAUSE: begin
        csr_write      = 1'b1;
        csr_write_addr = CSR_AW'(CSR_MCAUSE);
        csr_data       = cause_q;
`ifdef TRAP_MSTATUS_EN
        state_d        = S_T_STAT;
`else
        state_d        = S_T_JUMP;
`endif
      end
`ifdef TRAP_MSTATUS_EN
      S_T_STAT: begin
        csr_read_addr  = CSR_AW'(CSR_MSTATUS);
        csr_write      = 1'b1;
        csr_write_addr = CSR_AW'(CSR_MSTATUS);
        csr_data       = mstatus_new_s;
        state_d        = S_T_JUMP;
      end
      S_R_STAT: begin
        csr_read_addr  = CSR_AW'(CSR_MSTATUS);
        csr_write      = 1'b1;
        csr_write_addr = CSR_AW'(CSR_MSTATUS);
        csr_data       = mstatus_new_s;
        state_d        = S_R_JUMP;
      end
`endif
      S_T_JUMP: begin
        csr_read_addr  = CSR_AW'(CSR_MTVEC);
        redirect_valid = 1'b1;
        redirect_pc    = align4(csr_out);
        state_d        = S_IDLE;
      end
      S_R_JUMP: begin
        csr_read_addr  = CSR_AW'(CSR_MEPC);
        redirect_valid = 1'b1;
        redirect_pc    = align4(csr_out);
        state_d        = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ysyx_25040129_trap_seq.sv
// Directed self-checking bench for ysyx_25040129_trap_seq with a small
// behavioural CSR file. Follows TRAP_MSTATUS_EN the same way the RTL does.
module tb_ysyx_25040129_trap_seq;

  localparam logic [11:0] A_MSTATUS = 12'h300;
  localparam logic [11:0] A_MTVEC   = 12'h305;
  localparam logic [11:0] A_MEPC    = 12'h341;
  localparam logic [11:0] A_MCAUSE  = 12'h342;

  logic        clk = 1'b0;
  logic        rst;
  logic        trap_valid;
  logic [31:0] trap_cause;
  logic [31:0] trap_pc;
  logic        mret_valid;
  logic        req_ready;
  logic        exu_csr_we;
  logic [11:0] exu_csr_waddr;
  logic [31:0] exu_csr_wdata;
  logic [11:0] exu_csr_raddr;
  logic [31:0] exu_csr_rdata;
  logic        exu_stall;
  logic        csr_write;
  logic [11:0] csr_write_addr;
  logic [31:0] csr_data;
  logic [11:0] csr_read_addr;
  logic [31:0] csr_out;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  // CSR file model
  logic [31:0] m_mstatus = 32'h0;
  logic [31:0] m_mtvec   = 32'h0;
  logic [31:0] m_mepc    = 32'h0;
  logic [31:0] m_mcause  = 32'h0;
  int          redir_cnt = 0;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  ysyx_25040129_trap_seq #(.CSR_AW(12)) dut (
    .clk            (clk),
    .rst            (rst),
    .trap_valid     (trap_valid),
    .trap_cause     (trap_cause),
    .trap_pc        (trap_pc),
    .mret_valid     (mret_valid),
    .req_ready      (req_ready),
    .exu_csr_we     (exu_csr_we),
    .exu_csr_waddr  (exu_csr_waddr),
    .exu_csr_wdata  (exu_csr_wdata),
    .exu_csr_raddr  (exu_csr_raddr),
    .exu_csr_rdata  (exu_csr_rdata),
    .exu_stall      (exu_stall),
    .csr_write      (csr_write),
    .csr_write_addr (csr_write_addr),
    .csr_data       (csr_data),
    .csr_read_addr  (csr_read_addr),
    .csr_out        (csr_out),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  // CSR file combinational read
  always_comb begin
    case (csr_read_addr)
      A_MSTATUS: csr_out = m_mstatus;
      A_MTVEC:   csr_out = m_mtvec;
      A_MEPC:    csr_out = m_mepc;
      A_MCAUSE:  csr_out = m_mcause;
      default:   csr_out = 32'h0;
    endcase
  end

  // CSR file write port
  always @(posedge clk) begin
    if (csr_write) begin
      case (csr_write_addr)
        A_MSTATUS: m_mstatus <= csr_data;
        A_MTVEC:   m_mtvec   <= csr_data;
        A_MEPC:    m_mepc    <= csr_data;
        A_MCAUSE:  m_mcause  <= csr_data;
        default: ;
      endcase
    end
  end

  // Count redirect pulses seen by the IFU
  always @(posedge clk) begin
    if (redirect_valid) redir_cnt <= redir_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // EXU csrrw through the idle pass-through path
  task automatic exu_write(input logic [11:0] addr, input logic [31:0] data);
    exu_csr_we = 1'b1; exu_csr_waddr = addr; exu_csr_wdata = data;
    @(negedge clk);
    exu_csr_we = 1'b0;
  endtask

  // Trap sequence, cycle by cycle from the accept cycle
  task automatic do_trap(input logic [31:0] cause, input logic [31:0] pc,
                         input logic [31:0] exp_tvec, input logic with_mret,
                         input logic accept_wr, input logic [31:0] accept_data,
                         input logic busy_wr);
    int c0;
    c0 = redir_cnt;
    check_eq("accept_ready", req_ready, 32'd1);
    trap_valid = 1'b1; trap_cause = cause; trap_pc = pc; mret_valid = with_mret;
    exu_csr_we = accept_wr; exu_csr_waddr = A_MTVEC; exu_csr_wdata = accept_data;
    if (accept_wr) check_eq("accept_exu_pass", csr_write_addr, {20'h0, A_MTVEC});
    @(negedge clk);
    trap_valid = 1'b0; mret_valid = 1'b0; exu_csr_we = 1'b0;
    check_eq("epc_we", csr_write, 32'd1);
    check_eq("epc_addr", csr_write_addr, {20'h0, A_MEPC});
    check_eq("epc_data", csr_data, {pc[31:2], 2'b00});
    check_eq("epc_stall", exu_stall, 32'd1);
    check_eq("epc_ready", req_ready, 32'd0);
    check_eq("epc_rdata", exu_csr_rdata, 32'h0);
    if (busy_wr) begin
      exu_csr_we = 1'b1; exu_csr_waddr = A_MTVEC; exu_csr_wdata = 32'hDEAD_0000;
    end
    @(negedge clk);
    check_eq("cause_we", csr_write, 32'd1);
    check_eq("cause_addr", csr_write_addr, {20'h0, A_MCAUSE});
    check_eq("cause_data", csr_data, cause);
    check_eq("cause_redir", redirect_valid, 32'd0);
    if (busy_wr) check_eq("cause_stall", exu_stall, 32'd1);
    exu_csr_we = 1'b0;
`ifdef TRAP_MSTATUS_EN
    @(negedge clk);
    check_eq("tstat_addr", csr_write_addr, {20'h0, A_MSTATUS});
    check_eq("tstat_redir", redirect_valid, 32'd0);
`endif
    @(negedge clk);
    check_eq("tjump_valid", redirect_valid, 32'd1);
    check_eq("tjump_pc", redirect_pc, exp_tvec);
    check_eq("tjump_we", csr_write, 32'd0);
    @(negedge clk);
    check_eq("tdone_valid", redirect_valid, 32'd0);
    check_eq("tdone_pc", redirect_pc, 32'h0);
    check_eq("tdone_ready", req_ready, 32'd1);
    @(negedge clk); @(negedge clk);
    check_eq("trap_pulses", redir_cnt - c0, 32'd1);
  endtask

  // mret sequence
  task automatic do_mret(input logic [31:0] exp_pc, input logic [31:0] exp_mstatus_wr);
    int c0;
    c0 = redir_cnt;
    check_eq("mret_ready", req_ready, 32'd1);
    mret_valid = 1'b1;
    @(negedge clk);
    mret_valid = 1'b0;
`ifdef TRAP_MSTATUS_EN
    check_eq("rstat_we", csr_write, 32'd1);
    check_eq("rstat_addr", csr_write_addr, {20'h0, A_MSTATUS});
    check_eq("rstat_data", csr_data, exp_mstatus_wr);
    check_eq("rstat_redir", redirect_valid, 32'd0);
    @(negedge clk);
`endif
    check_eq("rjump_valid", redirect_valid, 32'd1);
    check_eq("rjump_pc", redirect_pc, exp_pc);
    check_eq("rjump_we", csr_write, 32'd0);
    @(negedge clk);
    check_eq("rdone_valid", redirect_valid, 32'd0);
    check_eq("rdone_ready", req_ready, 32'd1);
    @(negedge clk); @(negedge clk);
    check_eq("mret_pulses", redir_cnt - c0, 32'd1);
  endtask

  initial begin
    int c0;
    rst = 1'b1; trap_valid = 1'b0; trap_cause = 32'h0; trap_pc = 32'h0;
    mret_valid = 1'b0; exu_csr_we = 1'b0; exu_csr_waddr = 12'h0;
    exu_csr_wdata = 32'h0; exu_csr_raddr = 12'h0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_ready", req_ready, 32'd1);
    check_eq("rst_stall", exu_stall, 32'd0);
    check_eq("rst_redir", redirect_valid, 32'd0);
    check_eq("rst_rpc", redirect_pc, 32'h0);

    // 1: trap entry
    exu_write(A_MTVEC, 32'h8000_0200);
    exu_write(A_MSTATUS, 32'h0000_0008);
    exu_csr_raddr = A_MTVEC;
    #1 check_eq("idle_rdata", exu_csr_rdata, 32'h8000_0200);
    do_trap(32'd11, 32'h8000_0104, 32'h8000_0200, 1'b0, 1'b0, 32'h0, 1'b0);
    check_eq("s1_mepc", m_mepc, 32'h8000_0104);
    check_eq("s1_mcause", m_mcause, 32'd11);
`ifdef TRAP_MSTATUS_EN
    check_eq("s1_mstatus", m_mstatus, 32'h0000_1880);
`else
    check_eq("s1_mstatus", m_mstatus, 32'h0000_0008);
`endif

    // 2: mret
    exu_write(A_MEPC, 32'h8000_0108);
    exu_write(A_MSTATUS, 32'h0000_1880);
    do_mret(32'h8000_0108, 32'h0000_1888);
`ifdef TRAP_MSTATUS_EN
    check_eq("s2_mstatus", m_mstatus, 32'h0000_1888);
`else
    check_eq("s2_mstatus", m_mstatus, 32'h0000_1880);
`endif

    // 3: trap and mret together, trap wins
    do_trap(32'd2, 32'h8000_0400, 32'h8000_0200, 1'b1, 1'b0, 32'h0, 1'b0);
    check_eq("s3_mepc", m_mepc, 32'h8000_0400);

    // 4: EXU write in accept cycle lands, write while busy is blocked
    do_trap(32'd5, 32'h8000_0503, 32'h8000_0300, 1'b0, 1'b1, 32'h8000_0300, 1'b1);
    check_eq("s4_mtvec", m_mtvec, 32'h8000_0300);
    check_eq("s4_mepc", m_mepc, 32'h8000_0500);

    // 5: reset during T_CAUSE abandons the sequence
    c0 = redir_cnt;
    trap_valid = 1'b1; trap_cause = 32'd7; trap_pc = 32'h8000_0600;
    @(negedge clk);
    trap_valid = 1'b0;
    @(negedge clk);
    check_eq("s5_in_cause", csr_write_addr, {20'h0, A_MCAUSE});
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("s5_ready", req_ready, 32'd1);
    check_eq("s5_stall", exu_stall, 32'd0);
    check_eq("s5_redir", redirect_valid, 32'd0);
    for (int i = 0; i < 4; i++) @(negedge clk);
    check_eq("s5_pulses", redir_cnt - c0, 32'd0);
    check_eq("s5_ready2", req_ready, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
